up_counter: RTL and testbench

Free-running synchronous up-counter, default 4 bits, with asynchronous active-low reset. Used as a timebase or sequence generator.
- Counts every clock edge while out of reset.
- Wraps modulo (MAX_VAL+1).
- Provides a terminal-count flag, a wrap pulse and a Gray-coded copy of the count.

---
 rtl/up_counter_pkg.sv | 16 +
 rtl/up_counter_if.sv | 23 ++
 rtl/up_counter_gray_encoder.sv | 14 +
 rtl/up_counter.sv | 79 +++++++
 tb/tb_up_counter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/up_counter_pkg.sv
// Shared constants and the binary-to-Gray helper for the up_counter block and its neighbours.
`timescale 1ns/1ps
package up_counter_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_STEP   = 1;
   localparam int WRAP_CNT_W = 8;

   // Widest count the Gray helper handles; callers cast down to their own width.
   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/up_counter_if.sv
// Output bundle of up_counter. With UP_COUNTER_WRAP_STATS_EN defined it also carries wrap_cnt.
`timescale 1ns/1ps
interface up_counter_if
   import up_counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic [WIDTH-1:0]      q;
   logic                  tc;
   logic                  wrap;
   logic [WIDTH-1:0]      q_gray;
`ifdef UP_COUNTER_WRAP_STATS_EN
   logic [WRAP_CNT_W-1:0] wrap_cnt;

   modport master (output q, output tc, output wrap, output q_gray, output wrap_cnt);
   modport slave  (input  q, input  tc, input  wrap, input  q_gray, input  wrap_cnt);
`else
   modport master (output q, output tc, output wrap, output q_gray);
   modport slave  (input  q, input  tc, input  wrap, input  q_gray);
`endif

endinterface

// File: rtl/up_counter_gray_encoder.sv
// Combinational binary-to-Gray converter built on the package helper.
`timescale 1ns/1ps
module gray_encoder
   import up_counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = WIDTH'(bin2gray(GRAY_MAX_W'(bin)));

endmodule

// File: rtl/up_counter.sv
// Free-running modular up-counter with terminal count, wrap pulse and Gray copy.
// Defining UP_COUNTER_WRAP_STATS_EN adds a saturating count of wraps since reset.
`timescale 1ns/1ps
module up_counter
   import up_counter_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_VAL   = 2**WIDTH - 1,
   parameter int RESET_VAL = 0,
   parameter int STEP      = DEF_STEP
) (
   input  logic        clk,
   input  logic        rst,
   up_counter_if.master bus
);

   if (WIDTH < 1 || WIDTH > GRAY_MAX_W - 1 ||
       MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 ||
       RESET_VAL < 0 || RESET_VAL > MAX_VAL ||
       STEP < 1 || STEP > MAX_VAL) begin : g_illegal_params
      $fatal(1, "up_counter: illegal parameter combination");
   end

   // One spare bit so count + STEP cannot overflow when MAX_VAL is all ones.
   localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] MOD_EXT  = MAX_EXT + 1'b1;

   logic [WIDTH-1:0] count;
   logic             wrap_q;
   logic [WIDTH:0]   sum;
   logic             wrap_next;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] gray;

   always_comb begin
      sum        = {1'b0, count} + STEP_EXT;
      wrap_next  = (sum > MAX_EXT);
      count_next = wrap_next ? WIDTH'(sum - MOD_EXT) : WIDTH'(sum);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count  <= WIDTH'(RESET_VAL);
         wrap_q <= 1'b0;
      end else begin
         count  <= count_next;
         wrap_q <= wrap_next;
      end
   end

`ifdef UP_COUNTER_WRAP_STATS_EN
   logic [WRAP_CNT_W-1:0] wrap_cnt_q;

   // Counts on the same edge that raises wrap and sticks at all ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_cnt_q <= '0;
      end else if (wrap_next && wrap_cnt_q != {WRAP_CNT_W{1'b1}}) begin
         wrap_cnt_q <= wrap_cnt_q + 1'b1;
      end
   end

   assign bus.wrap_cnt = wrap_cnt_q;
`endif

   gray_encoder #(
      .WIDTH (WIDTH)
   ) u_gray_encoder (
      .bin  (count),
      .gray (gray)
   );

   assign bus.q      = count;
   assign bus.tc     = (count == MAX_EXT[WIDTH-1:0]);
   assign bus.wrap   = wrap_q;
   assign bus.q_gray = gray;

endmodule

// File: tb/tb_up_counter.sv
// Randomised self-checking bench for up_counter: default instance plus a MAX_VAL=9, STEP=3 instance.
// Wrap-statistics checks are compiled in when UP_COUNTER_WRAP_STATS_EN is defined.
`timescale 1ns/1ps
module tb_up_counter;

   localparam int M_A = 16;
   localparam int S_A = 1;
   localparam int M_B = 10;
   localparam int S_B = 3;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   n;

   up_counter_if #(.WIDTH(4)) bus_a ();
   up_counter_if #(.WIDTH(4)) bus_b ();

   up_counter #(
      .WIDTH (4)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   up_counter #(
      .WIDTH     (4),
      .MAX_VAL   (9),
      .RESET_VAL (0),
      .STEP      (3)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: after n counted edges the count is n*s mod m and n*s div m wraps have happened.
   function automatic int model_q(int steps, int s, int m);
      return (steps * s) % m;
   endfunction

   function automatic int model_wraps(int steps, int s, int m);
      return (steps * s) / m;
   endfunction

   function automatic bit model_wrap(int steps, int s, int m);
      return (steps > 0) && (model_wraps(steps, s, m) != model_wraps(steps - 1, s, m));
   endfunction

   function automatic logic [3:0] model_gray(int v);
      logic [3:0] b;
      b = 4'(v);
      return b ^ (b >> 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) n++;
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      n   = 0;
      @(posedge clk);
      #2;
      total += 5;
      if (bus_a.q !== 4'd0)      begin bad++; $display("[TB] FAIL reset_q: got %0d want 0", bus_a.q); end
      if (bus_a.tc !== 1'b0)     begin bad++; $display("[TB] FAIL reset_tc: got %0b want 0", bus_a.tc); end
      if (bus_a.wrap !== 1'b0)   begin bad++; $display("[TB] FAIL reset_wrap: got %0b want 0", bus_a.wrap); end
      if (bus_a.q_gray !== 4'd0) begin bad++; $display("[TB] FAIL reset_gray: got %0d want 0", bus_a.q_gray); end
      if (bus_b.q !== 4'd0)      begin bad++; $display("[TB] FAIL reset_q_b: got %0d want 0", bus_b.q); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_count_wrap();
      int wrap_cycles;
      bit saw_tc15;
      wrap_cycles = 0;
      saw_tc15    = 1'b0;
      for (int i = 0; i < 19; i++) begin
         tick();
         total += 4;
         if (bus_a.q !== 4'(model_q(n, S_A, M_A)))
            begin bad++; $display("[TB] FAIL count_q: got %0d want %0d", bus_a.q, model_q(n, S_A, M_A)); end
         if (bus_a.tc !== (model_q(n, S_A, M_A) == 15))
            begin bad++; $display("[TB] FAIL count_tc: got %0b at n=%0d", bus_a.tc, n); end
         if (bus_a.wrap !== model_wrap(n, S_A, M_A))
            begin bad++; $display("[TB] FAIL count_wrap: got %0b want %0b", bus_a.wrap, model_wrap(n, S_A, M_A)); end
         if (bus_a.q_gray !== model_gray(model_q(n, S_A, M_A)))
            begin bad++; $display("[TB] FAIL count_gray: got %0d want %0d", bus_a.q_gray, model_gray(model_q(n, S_A, M_A))); end
         if (bus_a.wrap === 1'b1) wrap_cycles++;
         if (bus_a.tc === 1'b1 && bus_a.q === 4'd15) saw_tc15 = 1'b1;
      end
      total += 3;
      if (bus_a.q !== 4'd3)  begin bad++; $display("[TB] FAIL end_q_19_edges: got %0d want 3", bus_a.q); end
      if (wrap_cycles != 1)  begin bad++; $display("[TB] FAIL wrap_pulse_count: got %0d want 1", wrap_cycles); end
      if (!saw_tc15)         begin bad++; $display("[TB] FAIL tc_at_15: got 0 want 1"); end
   endtask

   task automatic test_gray_sweep();
      logic [3:0] prev;
      prev = bus_a.q_gray;
      for (int i = 0; i < 16; i++) begin
         tick();
         total += 2;
         if (bus_a.q_gray !== model_gray(model_q(n, S_A, M_A)))
            begin bad++; $display("[TB] FAIL gray_value: got %0d want %0d", bus_a.q_gray, model_gray(model_q(n, S_A, M_A))); end
         if ($countones(bus_a.q_gray ^ prev) != 1)
            begin bad++; $display("[TB] FAIL gray_hamming: got %0d want 1", $countones(bus_a.q_gray ^ prev)); end
         if (model_q(n, S_A, M_A) == 5) begin
            total++;
            if (bus_a.q_gray !== 4'd7) begin bad++; $display("[TB] FAIL gray_of_5: got %0d want 7", bus_a.q_gray); end
         end
         prev = bus_a.q_gray;
      end
   endtask

   task automatic test_async_reset();
      int k;
      k = 0;
      while (model_q(n, S_A, M_A) != 9 && k < 40) begin
         tick();
         k++;
      end
      total++;
      if (bus_a.q !== 4'd9) begin bad++; $display("[TB] FAIL pre_reset_q: got %0d want 9", bus_a.q); end
      #1;
      rst = 1'b0;
      n   = 0;
      #1;
      total += 3;
      if (bus_a.q !== 4'd0)      begin bad++; $display("[TB] FAIL async_q: got %0d want 0", bus_a.q); end
      if (bus_a.wrap !== 1'b0)   begin bad++; $display("[TB] FAIL async_wrap: got %0b want 0", bus_a.wrap); end
      if (bus_a.q_gray !== 4'd0) begin bad++; $display("[TB] FAIL async_gray: got %0d want 0", bus_a.q_gray); end
      repeat (3) tick();
      total++;
      if (bus_a.q !== 4'd0) begin bad++; $display("[TB] FAIL held_q: got %0d want 0", bus_a.q); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         total++;
         if (bus_a.q !== 4'(i)) begin bad++; $display("[TB] FAIL resume_q: got %0d want %0d", bus_a.q, i); end
      end
   endtask

   task automatic test_step3();
      int seq[11];
      seq = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7, 0};
      #1;
      rst = 1'b0;
      n   = 0;
      @(negedge clk);
      rst = 1'b1;
      total++;
      if (bus_b.q !== 4'd0) begin bad++; $display("[TB] FAIL step3_start: got %0d want 0", bus_b.q); end
      for (int i = 1; i < 11; i++) begin
         tick();
         total += 3;
         if (bus_b.q !== 4'(seq[i]))
            begin bad++; $display("[TB] FAIL step3_q: got %0d want %0d", bus_b.q, seq[i]); end
         if (bus_b.wrap !== (seq[i] < seq[i-1]))
            begin bad++; $display("[TB] FAIL step3_wrap: got %0b at q=%0d", bus_b.wrap, seq[i]); end
         if (bus_b.tc !== (seq[i] == 9))
            begin bad++; $display("[TB] FAIL step3_tc: got %0b at q=%0d", bus_b.tc, seq[i]); end
      end
   endtask

   task automatic test_random();
      int len;
      int hold;
      for (int it = 0; it < 30; it++) begin
         len = $urandom_range(1, 25);
         for (int i = 0; i < len; i++) begin
            tick();
            total += 6;
            if (bus_a.q !== 4'(model_q(n, S_A, M_A)))
               begin bad++; $display("[TB] FAIL rand_q_a: got %0d want %0d", bus_a.q, model_q(n, S_A, M_A)); end
            if (bus_a.wrap !== model_wrap(n, S_A, M_A))
               begin bad++; $display("[TB] FAIL rand_wrap_a: got %0b want %0b", bus_a.wrap, model_wrap(n, S_A, M_A)); end
            if (bus_b.q !== 4'(model_q(n, S_B, M_B)))
               begin bad++; $display("[TB] FAIL rand_q_b: got %0d want %0d", bus_b.q, model_q(n, S_B, M_B)); end
            if (bus_b.wrap !== model_wrap(n, S_B, M_B))
               begin bad++; $display("[TB] FAIL rand_wrap_b: got %0b want %0b", bus_b.wrap, model_wrap(n, S_B, M_B)); end
            if (bus_b.tc !== (model_q(n, S_B, M_B) == 9))
               begin bad++; $display("[TB] FAIL rand_tc_b: got %0b at n=%0d", bus_b.tc, n); end
            if (bus_b.q_gray !== model_gray(model_q(n, S_B, M_B)))
               begin bad++; $display("[TB] FAIL rand_gray_b: got %0d want %0d", bus_b.q_gray, model_gray(model_q(n, S_B, M_B))); end
         end
         #($urandom_range(0, 6));
         rst = 1'b0;
         n   = 0;
         #1;
         total += 2;
         if (bus_a.q !== 4'd0) begin bad++; $display("[TB] FAIL rand_rst_a: got %0d want 0", bus_a.q); end
         if (bus_b.q !== 4'd0) begin bad++; $display("[TB] FAIL rand_rst_b: got %0d want 0", bus_b.q); end
         hold = $urandom_range(0, 3);
         repeat (hold) tick();
         @(negedge clk);
         rst = 1'b1;
      end
   endtask

`ifdef UP_COUNTER_WRAP_STATS_EN
   task automatic test_wrap_stats();
      int exp_a;
      int exp_b;
      #1;
      rst = 1'b0;
      n   = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 300 * 16; i++) begin
         tick();
         exp_a = model_wraps(n, S_A, M_A) > 255 ? 255 : model_wraps(n, S_A, M_A);
         exp_b = model_wraps(n, S_B, M_B) > 255 ? 255 : model_wraps(n, S_B, M_B);
         total += 2;
         if (bus_a.wrap_cnt !== 8'(exp_a))
            begin bad++; $display("[TB] FAIL wrap_cnt_a: got %0d want %0d", bus_a.wrap_cnt, exp_a); end
         if (bus_b.wrap_cnt !== 8'(exp_b))
            begin bad++; $display("[TB] FAIL wrap_cnt_b: got %0d want %0d", bus_b.wrap_cnt, exp_b); end
      end
      total++;
      if (bus_a.wrap_cnt !== 8'd255) begin bad++; $display("[TB] FAIL wrap_cnt_sat: got %0d want 255", bus_a.wrap_cnt); end
      #1;
      rst = 1'b0;
      n   = 0;
      #1;
      total++;
      if (bus_a.wrap_cnt !== 8'd0) begin bad++; $display("[TB] FAIL wrap_cnt_reset: got %0d want 0", bus_a.wrap_cnt); end
      @(negedge clk);
      rst = 1'b1;
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      n     = 0;
      rst   = 1'b0;
      test_reset();
      test_count_wrap();
      test_gray_sweep();
      test_async_reset();
      test_step3();
      test_random();
`ifdef UP_COUNTER_WRAP_STATS_EN
      test_wrap_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
